// File: rtl/tinynpu_hps_pkg.sv
// Shared types for the HPS command sequencer: wait modes, FSM states, counter width.
package tinynpu_hps_pkg;

  typedef enum logic [1:0] {
    WM_NONE  = 2'd0,
    WM_RISE  = 2'd1,
    WM_LEVEL = 2'd2
  } wait_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  localparam int CMD_CNT_W = 16;

endpackage

// File: rtl/hps_cmd_fifo.sv
// Show-ahead synchronous FIFO: pop_data always presents the oldest entry while not empty.
module hps_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_reg == (AW+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];
  assign level    = level_reg;

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/hps_cmd_sequencer.sv
// Queues PIO command words, strobes each onto h2f_pio and waits for a selectable f2h_pio done bit.
// Optional WAIT timeout with sticky err is enabled by defining CMD_TIMEOUT_EN.
module hps_cmd_sequencer
  import tinynpu_hps_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int SEL_W       = $clog2(DATA_W),
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [1:0]               cmd_mode,
  input  logic [SEL_W-1:0]         cmd_sel,
  input  logic                     flush,
  output logic [DATA_W-1:0]        h2f_pio,
  output logic                     h2f_write,
  input  logic [DATA_W-1:0]        f2h_pio,
  output logic                     busy,
  output logic                     done_pulse,
  output logic [CMD_CNT_W-1:0]     cmd_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err
);

  localparam int ENTRY_W = 2 + SEL_W + DATA_W;

  seq_state_e          state_reg, state_next;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_dout;
  logic                pop;
  logic [1:0]          mode_reg;
  logic [SEL_W-1:0]    sel_reg;
  logic [DATA_W-1:0]   h2f_pio_reg;
  logic [DATA_W-1:0]   f2h_prev_reg;
  logic                done_pulse_reg;
  logic [CMD_CNT_W-1:0] cmd_count_reg;
  logic                hit;
  logic                timeout;
  logic                waits;

  hps_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (cmd_valid),
    .push_data ({cmd_mode, cmd_sel, cmd_data}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign cmd_ready  = !fifo_full;
  assign h2f_pio    = h2f_pio_reg;
  assign h2f_write  = (state_reg == S_ISSUE);
  assign busy       = !fifo_empty || (state_reg != S_IDLE);
  assign done_pulse = done_pulse_reg;
  assign cmd_count  = cmd_count_reg;

  // Reserved mode 3 falls through to NONE.
  assign waits = (mode_reg == WM_RISE) || (mode_reg == WM_LEVEL);

  always_comb begin
    hit = 1'b0;
    if (mode_reg == WM_RISE) begin
      hit = f2h_pio[sel_reg] && !f2h_prev_reg[sel_reg];
    end else if (mode_reg == WM_LEVEL) begin
      hit = f2h_pio[sel_reg];
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Hold off one cycle while the previous completion is reported, spacing strobes 4 apart.
        if (!fifo_empty && !done_pulse_reg) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = waits ? S_WAIT : S_DONE;
      S_WAIT: begin
        if (hit) begin
          state_next = S_DONE;
        end else if (timeout) begin
          state_next = S_IDLE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      mode_reg       <= '0;
      sel_reg        <= '0;
      h2f_pio_reg    <= '0;
      f2h_prev_reg   <= '0;
      done_pulse_reg <= 1'b0;
      cmd_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      f2h_prev_reg   <= f2h_pio;
      done_pulse_reg <= (state_reg == S_DONE) && !flush;
      if ((state_reg == S_DONE) && !flush) begin
        cmd_count_reg <= cmd_count_reg + 1'b1;
      end
      if (pop) begin
        {mode_reg, sel_reg, h2f_pio_reg} <= fifo_dout;
      end
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_cnt_reg;
  logic        err_reg;

  // Fires during the last budgeted WAIT cycle, so err rises after exactly TIMEOUT_CYC WAIT cycles.
  assign timeout = (wait_cnt_reg == TO_LAST);
  assign err     = err_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == S_ISSUE) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == S_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if ((state_reg == S_WAIT) && !hit && timeout) begin
        err_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
